// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, control-bundle bit positions
// and the all-zero bubble encoding.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam int WB_W   = 2;
  localparam int M_W    = 3;
  localparam int EX_W   = 4;
  localparam int CTRL_W = WB_W + M_W + EX_W;

  // {regwrite, memtoreg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // {branch, memread, memwrite}
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // {regdst, aluop[1:0], alusrc}; EX_ALUOP is the low bit of the 2-bit field
  localparam int EX_REGDST = 3;
  localparam int EX_ALUOP  = 1;
  localparam int EX_ALUSRC = 0;

  localparam logic [CTRL_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the rt of a
// load currently held in EX. Purely combinational.
module hazard_detect #(
  parameter int ADDR_W = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_memread,
  input  logic [ADDR_W-1:0] i_ex_rt,
  input  logic [ADDR_W-1:0] i_id_rs,
  input  logic [ADDR_W-1:0] i_id_rt,
  output logic              o_raw
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_ex_rt == i_id_rs);
  assign w_rt_hit = (i_ex_rt == i_id_rt);

  // $zero never carries a real dependency
  assign o_raw = i_ex_valid & i_ex_memread & (i_ex_rt != '0) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline latch with load-use bubble insertion, write-back bypass
// onto captured operands and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        id_A,
  input  logic [DATA_W-1:0]        id_B,
  input  logic [ADDR_W-1:0]        id_rs,
  input  logic [ADDR_W-1:0]        id_rt,
  input  logic [ADDR_W-1:0]        id_rd,
  input  logic [DATA_W-1:0]        id_imm,
  input  logic [DATA_W-1:0]        id_npc,
  input  logic [mips_pkg::WB_W-1:0] id_wb,
  input  logic [mips_pkg::M_W-1:0]  id_m,
  input  logic [mips_pkg::EX_W-1:0] id_ex,
  input  logic                     wb_regwrite,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]        wb_writedata,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [DATA_W-1:0]        ex_A,
  output logic [DATA_W-1:0]        ex_B,
  output logic [DATA_W-1:0]        ex_imm,
  output logic [DATA_W-1:0]        ex_npc,
  output logic [ADDR_W-1:0]        ex_rs,
  output logic [ADDR_W-1:0]        ex_rt,
  output logic [ADDR_W-1:0]        ex_rd,
  output logic [mips_pkg::WB_W-1:0] ex_wb,
  output logic [mips_pkg::M_W-1:0]  ex_m,
  output logic [mips_pkg::EX_W-1:0] ex_ex,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  import mips_pkg::*;

  logic              r_valid;
  logic [DATA_W-1:0] r_A, r_B, r_imm, r_npc;
  logic [ADDR_W-1:0] r_rs, r_rt, r_rd;
  logic [WB_W-1:0]   r_wb;
  logic [M_W-1:0]    r_m;
  logic [EX_W-1:0]   r_ex;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic              w_raw;
  logic              w_stall;
  logic [DATA_W-1:0] w_byp_A, w_byp_B;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Register file writes in the same cycle it is read, so the value being
  // written back is newer than what the read ports show.
  function automatic logic [DATA_W-1:0] bypass(
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] rf
  );
    return (we && (wa != '0) && (wa == src)) ? wd : rf;
  endfunction

  hazard_detect #(
    .ADDR_W (ADDR_W)
  ) u_hazard (
    .i_ex_valid   (r_valid),
    .i_ex_memread (r_m[M_MEMREAD]),
    .i_ex_rt      (r_rt),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .o_raw        (w_raw)
  );

  assign w_stall = w_raw & ~flush & ~hold;
  assign w_byp_A = bypass(wb_regwrite, wb_rd, wb_writedata, id_rs, id_A);
  assign w_byp_B = bypass(wb_regwrite, wb_rd, wb_writedata, id_rt, id_B);

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid            <= 1'b0;
      r_A                <= '0;
      r_B                <= '0;
      r_imm              <= '0;
      r_npc              <= '0;
      r_rs               <= '0;
      r_rt               <= '0;
      r_rd               <= '0;
      {r_wb, r_m, r_ex}  <= BUBBLE;
      r_stall_cnt        <= '0;
      r_flush_cnt        <= '0;
    end else if (!hold) begin
      if (flush || w_stall) begin
        r_valid           <= 1'b0;
        r_A               <= '0;
        r_B               <= '0;
        r_imm             <= '0;
        r_npc             <= '0;
        r_rs              <= '0;
        r_rt              <= '0;
        r_rd              <= '0;
        {r_wb, r_m, r_ex} <= BUBBLE;
        if (flush) r_flush_cnt <= sat_inc(r_flush_cnt);
        else       r_stall_cnt <= sat_inc(r_stall_cnt);
      end else begin
        r_valid <= 1'b1;
        r_A     <= w_byp_A;
        r_B     <= w_byp_B;
        r_imm   <= id_imm;
        r_npc   <= id_npc;
        r_rs    <= id_rs;
        r_rt    <= id_rt;
        r_rd    <= id_rd;
        r_wb    <= id_wb;
        r_m     <= id_m;
        r_ex    <= id_ex;
      end
    end
  end

  assign stall     = w_stall;
  assign ex_valid  = r_valid;
  assign ex_A      = r_A;
  assign ex_B      = r_B;
  assign ex_imm    = r_imm;
  assign ex_npc    = r_npc;
  assign ex_rs     = r_rs;
  assign ex_rt     = r_rt;
  assign ex_rd     = r_rd;
  assign ex_wb     = r_wb;
  assign ex_m      = r_m;
  assign ex_ex     = r_ex;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, bypass, load-use,
// flush/hold priority and counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, flush;
  logic [31:0] id_A, id_B, id_imm, id_npc;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_wb;
  logic [2:0]  id_m;
  logic [3:0]  id_ex;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_writedata;
  logic        stall, ex_valid;
  logic [31:0] ex_A, ex_B, ex_imm, ex_npc;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [1:0]  ex_wb;
  logic [2:0]  ex_m;
  logic [3:0]  ex_ex;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_A(id_A), .id_B(id_B), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm(id_imm), .id_npc(id_npc), .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_writedata(wb_writedata),
    .stall(stall), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
    .ex_imm(ex_imm), .ex_npc(ex_npc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    hold = 0; flush = 0;
    id_A = 0; id_B = 0; id_imm = 0; id_npc = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_wb = 0; id_m = 0; id_ex = 0;
    wb_regwrite = 0; wb_rd = 0; wb_writedata = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    id_rs = rs; id_rt = rt; id_rd = rd; id_A = a; id_B = b; id_m = m;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    #12;
    rst_n = 1;
    // latch a load to rt=6, then present a dependent instruction: stall high
    set_instr(5'd1, 5'd6, 5'd0, 32'h11, 32'h22, 3'b010);
    id_wb = 2'b11; id_ex = 4'b0011; id_imm = 32'h4; id_npc = 32'h104;
    tick();
    set_instr(5'd6, 5'd2, 5'd3, 32'hDEAD, 32'h1, 3'b000);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL reset_setup_stall got %0b want 1", stall); end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({ex_valid, stall} !== 2'b00) begin errors++; $display("FAIL reset_valid_stall got %b want 00", {ex_valid, stall}); end
    checks++;
    if ({ex_A, ex_B, ex_imm, ex_npc} !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", {ex_A, ex_B, ex_imm, ex_npc}); end
    checks++;
    if ({ex_rs, ex_rt, ex_rd, ex_wb, ex_m, ex_ex} !== 24'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", {ex_rs, ex_rt, ex_rd, ex_wb, ex_m, ex_ex}); end
    checks++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", {stall_cnt, flush_cnt}); end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_A !== 32'hDEAD || ex_rs !== 5'd6) begin
      errors++; $display("FAIL reset_release_capture got v=%0b A=%h rs=%0d want v=1 A=dead rs=6", ex_valid, ex_A, ex_rs);
    end
  endtask

  task automatic test_capture;
    idle_inputs();
    set_instr(5'd2, 5'd3, 5'd4, 32'd5, 32'd100, 3'b000);
    id_wb = 2'b10; id_ex = 4'b1100; id_imm = 32'hFFFF_FFF8; id_npc = 32'h0000_0404;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_A !== 32'd5 || ex_B !== 32'd100) begin
      errors++; $display("FAIL capture_ops got v=%0b A=%0d B=%0d want v=1 A=5 B=100", ex_valid, ex_A, ex_B);
    end
    checks++;
    if ({ex_wb, ex_m, ex_ex} !== 9'b10_000_1100) begin
      errors++; $display("FAIL capture_ctrl got %b want 100001100", {ex_wb, ex_m, ex_ex});
    end
    checks++;
    if (ex_imm !== 32'hFFFF_FFF8 || ex_npc !== 32'h404 || {ex_rs, ex_rt, ex_rd} !== {5'd2, 5'd3, 5'd4}) begin
      errors++; $display("FAIL capture_fields got imm=%h npc=%h rs=%0d rt=%0d rd=%0d want fffffff8 404 2 3 4", ex_imm, ex_npc, ex_rs, ex_rt, ex_rd);
    end
  endtask

  task automatic test_bypass;
    idle_inputs();
    set_instr(5'd2, 5'd3, 5'd1, 32'd9, 32'd0, 3'b000);
    wb_regwrite = 1; wb_rd = 5'd3; wb_writedata = 32'd100;
    tick();
    checks++;
    if (ex_B !== 32'd100 || ex_A !== 32'd9) begin
      errors++; $display("FAIL bypass_B got A=%0d B=%0d want A=9 B=100", ex_A, ex_B);
    end
    set_instr(5'd5, 5'd0, 5'd1, 32'd1, 32'd55, 3'b000);
    wb_rd = 5'd0; wb_writedata = 32'd100;
    tick();
    checks++;
    if (ex_B !== 32'd55) begin errors++; $display("FAIL bypass_r0 got B=%0d want 55", ex_B); end
    set_instr(5'd5, 5'd7, 5'd1, 32'd1, 32'd2, 3'b000);
    wb_rd = 5'd5; wb_writedata = 32'd77;
    tick();
    checks++;
    if (ex_A !== 32'd77 || ex_B !== 32'd2) begin
      errors++; $display("FAIL bypass_A got A=%0d B=%0d want A=77 B=2", ex_A, ex_B);
    end
    wb_regwrite = 0;
    tick();
    checks++;
    if (ex_A !== 32'd1) begin errors++; $display("FAIL bypass_noen got A=%0d want 1", ex_A); end
  endtask

  task automatic test_load_use;
    idle_inputs();
    set_instr(5'd1, 5'd6, 5'd0, 32'd0, 32'd0, 3'b010);
    tick();
    set_instr(5'd6, 5'd9, 5'd10, 32'd3, 32'd4, 3'b000);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %0b want 1", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_m !== 3'b000 || stall_cnt !== 16'd1 || stall !== 1'b0) begin
      errors++; $display("FAIL loaduse_bubble got v=%0b m=%b cnt=%0d stall=%0b want 0 000 1 0", ex_valid, ex_m, stall_cnt, stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs !== 5'd6 || ex_A !== 32'd3 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL loaduse_resume got v=%0b rs=%0d A=%0d cnt=%0d want 1 6 3 1", ex_valid, ex_rs, ex_A, stall_cnt);
    end
  endtask

  task automatic test_back_to_back;
    idle_inputs();
    set_instr(5'd1, 5'd7, 5'd0, 32'd0, 32'd0, 3'b010);
    tick();
    // second load reads the first load's rt through its own rt port
    set_instr(5'd2, 5'd7, 5'd0, 32'd0, 32'd0, 3'b010);
    tick();
    checks++;
    if (ex_valid !== 1'b0 || stall_cnt !== 16'd2) begin
      errors++; $display("FAIL b2b_first got v=%0b cnt=%0d want 0 2", ex_valid, stall_cnt);
    end
    tick();
    set_instr(5'd7, 5'd7, 5'd3, 32'd0, 32'd0, 3'b000);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL b2b_second_stall got %0b want 1", stall); end
    tick();
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || stall_cnt !== 16'd3) begin
      errors++; $display("FAIL b2b_done got v=%0b rd=%0d cnt=%0d want 1 3 3", ex_valid, ex_rd, stall_cnt);
    end
  endtask

  task automatic test_flush_over_stall;
    idle_inputs();
    set_instr(5'd1, 5'd6, 5'd0, 32'd0, 32'd0, 3'b010);
    tick();
    set_instr(5'd6, 5'd0, 5'd2, 32'd8, 32'd0, 3'b000);
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall_out got %0b want 0", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin
      errors++; $display("FAIL flush_over_stall got v=%0b fc=%0d sc=%0d want 0 1 3", ex_valid, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_hold;
    idle_inputs();
    set_instr(5'd1, 5'd6, 5'd0, 32'h33, 32'h44, 3'b010);
    tick();
    set_instr(5'd6, 5'd0, 5'd2, 32'h99, 32'h0, 3'b000);
    hold = 1; flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL hold_stall_out got %0b want 0", stall); end
    tick();
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_m !== 3'b010 || ex_rt !== 5'd6 || ex_A !== 32'h33) begin
      errors++; $display("FAIL hold_keep got v=%0b m=%b rt=%0d A=%h want 1 010 6 33", ex_valid, ex_m, ex_rt, ex_A);
    end
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin
      errors++; $display("FAIL hold_cnt got fc=%0d sc=%0d want 1 3", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_saturation;
    idle_inputs();
    rst_n = 0;
    #2;
    rst_n = 1;
    flush = 1;
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (flush_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %h want fffe", flush_cnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (flush_cnt !== 16'hFFFF || stall_cnt !== 16'h0) begin
      errors++; $display("FAIL sat_full got fc=%h sc=%h want ffff 0000", flush_cnt, stall_cnt);
    end
    flush = 0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bypass();
    test_load_use();
    test_back_to_back();
    test_flush_over_stall();
    test_hold();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline latch placed directly downstream of the register file in the five-stage MIPS datapath.
- Captures the register-file read ports A/B, the decoded fields, the immediate, next-PC and the control bundles on each clock.
- Detects load-use hazards against the instruction it currently holds, inserts bubbles, and applies same-cycle write-back bypass onto captured operands.
- Keeps saturating stall/flush event counters for lab performance reporting.

Parameters:
DATA_W, 32, operand/immediate/PC width
ADDR_W, 5, register address width
CNT_W, 16, event counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
hold  in  1  global freeze (memory wait); highest priority
flush  in  1  squash instruction in ID (branch taken)
id_A  in  DATA_W  register file read port A (rs data)
id_B  in  DATA_W  register file read port B (rt data)
id_rs, id_rt, id_rd  in  ADDR_W  decoded register fields
id_imm  in  DATA_W  sign-extended immediate
id_npc  in  DATA_W  PC+4 from IF/ID
id_wb  in  2  {regwrite, memtoreg}
id_m  in  3  {branch, memread, memwrite}
id_ex  in  4  {regdst, aluop[1:0], alusrc}
wb_regwrite  in  1  write-back enable (same signal driving register file regwrite)
wb_rd  in  ADDR_W  write-back destination
wb_writedata  in  DATA_W  write-back data
stall  out  1  load-use stall request to PC and IF/ID (hold them)
ex_valid  out  1  latched instruction is real (not bubble)
ex_A, ex_B, ex_imm, ex_npc  out  DATA_W  latched operands
ex_rs, ex_rt, ex_rd  out  ADDR_W  latched fields
ex_wb, ex_m, ex_ex  out  2/3/4  latched control bundles
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including ex_valid, counters and control bundles. The stall output is therefore 0.
- stall is combinational from latched state and current ID inputs:
  - raw = ex_valid & ex_m[1] & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt)
  - stall = raw & ~flush & ~hold
- Rising clk, in priority order:
  1. hold=1: all registers keep their value; counters unchanged.
  2. flush=1: load a bubble (all data/field/control outputs 0, ex_valid=0). flush_cnt += 1, saturating.
  3. stall=1: load a bubble. stall_cnt += 1, saturating.
  4. Otherwise: capture all id_* inputs and set ex_valid=1.
- Capture is one-cycle latency: inputs present before edge N appear on ex_* after edge N.
- Bypass applies on capture:
  - ex_A = wb_writedata if wb_regwrite & wb_rd != 0 & wb_rd == id_rs; otherwise id_A.
  - ex_B uses the same rule against id_rt.
  - Register 0 is never bypassed.
- A load-use stall lasts exactly one cycle. The bubble clears ex_m[1], so the next cycle captures the dependent instruction.
- A back-to-back dependency chain of loads stalls once per load.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall: outputs clear immediately and stall drops combinationally. After release, the first edge captures normally.
- Simultaneous flush and stall condition: flush wins, stall output is 0, only flush_cnt increments.
- Simultaneous hold and flush: nothing changes; flush must be re-presented by upstream.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and ADDR_W constants
  - control bundle widths
  - bit-index constants WB_REGWRITE, WB_MEMTOREG, M_BRANCH, M_MEMREAD, M_MEMWRITE, EX_REGDST, EX_ALUOP, EX_ALUSRC
  - BUBBLE value (all zeros)
- One sub-module, hazard_detect: purely combinational load-use comparator producing raw. It is reused later by the forwarding unit.
- Latch, bypass muxes and counters stay in id_ex_stage.

Test Plan:
- Reset: rst_n=0 with id_A=0xDEAD and ex state nonzero -> all ex_* = 0, ex_valid=0, stall=0, counters=0 without a clock edge.
- Normal capture: id_rs=2, id_rt=3, id_A=5, id_B=100, id_wb=2'b10, no write-back -> after one edge ex_A=5, ex_B=100, ex_wb=2'b10, ex_valid=1.
- Bypass: id_rt=3, id_B=0, wb_regwrite=1, wb_rd=3, wb_writedata=100 -> ex_B=100. Same stimulus with wb_rd=0, id_rt=0 -> ex_B=id_B.
- Load-use: latched lw (ex_m=3'b010, ex_rt=6), next ID id_rs=6 -> stall=1 for one cycle, bubble latched (ex_valid=0), stall_cnt=1. Following edge captures the dependent instruction with ex_valid=1.
- Flush over stall: same load-use setup plus flush=1 -> stall=0, bubble latched, flush_cnt=1, stall_cnt=0. Adding hold=1 instead -> ex_* unchanged, counters unchanged.
- Saturation: force 2^CNT_W+3 flushes -> flush_cnt stays 16'hFFFF.
